// File: rtl/imem_resp_pkg.sv
// imem_resp_pkg: shared types and constants for the instruction-memory responder.
//   IM_ADDR_LEN / IM_DATA_LEN : fetch port address and data widths
//   state_e                   : responder state {IDLE, WAIT, RD}
//   BAD_PF / BAD_XES          : bit positions inside imem_bad
//   classify()                : fault classification of a fetch at accept time
package imem_resp_pkg;

  localparam int unsigned IM_ADDR_LEN = 32;
  localparam int unsigned IM_DATA_LEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD
  } state_e;

  localparam int unsigned BAD_PF  = 0;
  localparam int unsigned BAD_XES = 1;

  // Page fault wins over window/alignment faults.
  function automatic logic [1:0] classify(input logic pf,
                                          input logic in_win,
                                          input logic aligned);
    logic [1:0] bad;
    bad = '0;
    if (pf)
      bad[BAD_PF] = 1'b1;
    else if (!in_win || !aligned)
      bad[BAD_XES] = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/imem_resp_lbuf.sv
// imem_resp_lbuf: one-entry instruction line buffer {valid, tag, data}.
//   clk, rst          : clock, synchronous active-high reset (clears valid)
//   fence_i           : invalidates the entry; also masks a same-cycle hit
//   lookup_tag        : word tag of the fetch being accepted
//   hit, hit_data     : lookup result (hit_data is the stored word)
//   fill_en/tag/data  : write the entry; a fill coincident with fence_i is dropped
module imem_resp_lbuf
  import imem_resp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fence_i,
  input  logic [IM_ADDR_LEN-3:0] lookup_tag,
  output logic                   hit,
  output logic [IM_DATA_LEN-1:0] hit_data,
  input  logic                   fill_en,
  input  logic [IM_ADDR_LEN-3:0] fill_tag,
  input  logic [IM_DATA_LEN-1:0] fill_data
);

  logic                   valid_q;
  logic [IM_ADDR_LEN-3:0] tag_q;
  logic [IM_DATA_LEN-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fence_i) begin
      valid_q <= 1'b0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= fill_data;
    end
  end

  always_comb begin
    hit      = valid_q && (tag_q == lookup_tag) && !fence_i;
    hit_data = data_q;
  end

endmodule

// File: rtl/imem_resp.sv
// imem_resp: responder end of the core's instruction fetch port, backed by a
// tightly-coupled synchronous SRAM. One fetch outstanding at a time, WAIT_CYC
// wait states before the SRAM read, faults reported on imem_bad.
//   clk, rst            : clock, synchronous active-high reset
//   imem_req/addr/pf    : fetch request, byte address, translation page fault
//   fence_i             : line buffer invalidate (ignored without the buffer)
//   imem_rdata/bad/busy : fetched word, {xes_fault, page_fault}, response pending
//   sram_cs/addr/rdata  : SRAM read strobe, word address, data (1-cycle latency)
// Optional feature: define IMEM_RESP_LBUF_EN to add a one-entry line buffer.
module imem_resp
  import imem_resp_pkg::*;
#(
  parameter logic [IM_ADDR_LEN-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [IM_ADDR_LEN-1:0] SIZE_BYTES = 32'h0001_0000,
  parameter int unsigned            WAIT_CYC   = 0,
  parameter int unsigned            SRAM_AW    = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_req,
  input  logic [IM_ADDR_LEN-1:0] imem_addr,
  input  logic                   imem_pf,
  input  logic                   fence_i,
  output logic [IM_DATA_LEN-1:0] imem_rdata,
  output logic [1:0]             imem_bad,
  output logic                   imem_busy,
  output logic                   sram_cs,
  output logic [SRAM_AW-1:0]     sram_addr,
  input  logic [IM_DATA_LEN-1:0] sram_rdata
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [SRAM_AW-1:0]     addr_q;
  logic [1:0]             bad_q;
  logic                   hit_q;
  logic [IM_DATA_LEN-1:0] hit_data_q;
  logic [IM_DATA_LEN-1:0] hold_q;

  logic                   accept;
  logic [IM_ADDR_LEN-1:0] win_off;
  logic [1:0]             bad_now;
  logic                   hit_now;
  logic                   go_sram_now;
  logic [IM_DATA_LEN-1:0] rd_data;
  logic                   lbuf_hit;
  logic [IM_DATA_LEN-1:0] lbuf_data;

  always_comb begin
    imem_busy   = (state_q == WAIT);
    accept      = imem_req && !imem_busy;
    // Unsigned offset compare: addresses below BASE wrap high and fault.
    win_off     = imem_addr - BASE_ADDR;
    bad_now     = classify(imem_pf, win_off < SIZE_BYTES, imem_addr[1:0] == 2'b00);
    hit_now     = (bad_now == 2'b00) && lbuf_hit;
    go_sram_now = (bad_now == 2'b00) && !lbuf_hit;

    // Response word in RD: buffer hit, SRAM pass-through, or zero on a fault.
    if (hit_q)
      rd_data = hit_data_q;
    else if (bad_q != 2'b00)
      rd_data = '0;
    else
      rd_data = sram_rdata;

    imem_rdata = (state_q == RD) ? rd_data : hold_q;
    imem_bad   = bad_q;

    // Zero wait states strobe the SRAM straight from the accept; otherwise
    // the strobe comes from the registered address on the last WAIT cycle.
    if (WAIT_CYC == 0) begin
      sram_cs   = !rst && accept && go_sram_now;
      sram_addr = imem_addr[SRAM_AW+1:2];
    end else begin
      sram_cs   = !rst && (state_q == WAIT) && (cnt_q == '0) && (bad_q == 2'b00);
      sram_addr = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      bad_q      <= '0;
      hit_q      <= 1'b0;
      hit_data_q <= '0;
      hold_q     <= '0;
    end else begin
      if (state_q == RD)
        hold_q <= rd_data;

      case (state_q)
        WAIT: begin
          if (cnt_q == '0)
            state_q <= RD;
          else
            cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase

      // Accept is only possible from IDLE or RD, so it overrides the above.
      if (accept) begin
        addr_q     <= imem_addr[SRAM_AW+1:2];
        bad_q      <= bad_now;
        hit_q      <= hit_now;
        hit_data_q <= lbuf_data;
        if (WAIT_CYC == 0 || hit_now) begin
          state_q <= RD;
        end else begin
          state_q <= WAIT;
          cnt_q   <= CNT_LOAD;
        end
      end
    end
  end

`ifdef IMEM_RESP_LBUF_EN
  logic [IM_ADDR_LEN-3:0] tag_q;

  always_ff @(posedge clk) begin
    if (rst)
      tag_q <= '0;
    else if (accept)
      tag_q <= imem_addr[IM_ADDR_LEN-1:2];
  end

  // Faulted fetches never fill, so a later clean fetch cannot hit on them.
  imem_resp_lbuf u_lbuf (
    .clk        (clk),
    .rst        (rst),
    .fence_i    (fence_i),
    .lookup_tag (imem_addr[IM_ADDR_LEN-1:2]),
    .hit        (lbuf_hit),
    .hit_data   (lbuf_data),
    .fill_en    ((state_q == RD) && (bad_q == 2'b00)),
    .fill_tag   (tag_q),
    .fill_data  (rd_data)
  );
`else
  logic unused_fence;

  assign lbuf_hit     = 1'b0;
  assign lbuf_data    = '0;
  assign unused_fence = fence_i;
`endif

endmodule
